// File: rtl/canny_pkg.sv
// canny_pkg: shared frame geometry and 3x3 window slice indices for the Canny pipeline
package canny_pkg;
  localparam int IMG_W  = 514;
  localparam int IMG_H  = 480;
  localparam int DATA_W = 8;
  localparam int X_W    = $clog2(IMG_W);
  localparam int Y_W    = $clog2(IMG_H);
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;
endpackage

// File: rtl/pixel_pos_counter.sv
// pixel_pos_counter: coordinates of the last absorbed pixel, with sof restart, frame wrap and eof
module pixel_pos_counter #(
  parameter int IMG_W = canny_pkg::IMG_W,
  parameter int IMG_H = canny_pkg::IMG_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     sof_i,
  output logic [$clog2(IMG_W)-1:0] x_o,
  output logic [$clog2(IMG_H)-1:0] y_o,
  output logic                     eof_o
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic started_q, eof_q, eof_d, restart, last_x, last_y;
  // until the first pixel is absorbed the held (0,0) is not a real pixel, so the next one is (0,0)
  always_comb begin
    restart = sof_i || !started_q;
    last_x  = x_q == X_W'(IMG_W - 1);
    last_y  = y_q == Y_W'(IMG_H - 1);
    x_d     = !en_i ? x_q : (restart || last_x) ? '0 : x_q + 1'b1;
    y_d     = (!en_i || (!restart && !last_x)) ? y_q : (restart || last_y) ? '0 : y_q + 1'b1;
    eof_d   = en_i && x_d == X_W'(IMG_W - 1) && y_d == Y_W'(IMG_H - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      started_q <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      started_q <= started_q || en_i;
      eof_q     <= eof_d;
    end
  end
  assign x_o   = x_q;
  assign y_o   = y_q;
  assign eof_o = eof_q;
endmodule

// File: rtl/window_3x3_assembler.sv
// window_3x3_assembler: shifts line-buffer column taps into a 3x3 window and flags in-image windows
module window_3x3_assembler #(
  parameter int IMG_W  = canny_pkg::IMG_W,
  parameter int IMG_H  = canny_pkg::IMG_H,
  parameter int DATA_W = canny_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic                     sof,
  input  logic [DATA_W-1:0]        tap_top,
  input  logic [DATA_W-1:0]        tap_mid,
  input  logic [DATA_W-1:0]        tap_bot,
  output logic [9*DATA_W-1:0]      win,
  output logic                     win_valid,
  output logic [$clog2(IMG_W)-1:0] cx,
  output logic [$clog2(IMG_H)-1:0] cy,
  output logic                     eof
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  logic ld_q, sof_q, cap_q, pos_eof, in_img;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [8:0][DATA_W-1:0] win_q, win_d;
  pixel_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk   (clk),
    .rst   (rst),
    .en_i  (ld_q),
    .sof_i (sof_q),
    .x_o   (x),
    .y_o   (y),
    .eof_o (pos_eof)
  );
  // windows whose oldest column wraps from the previous line, or that reach above row 0, are masked
  assign in_img = cap_q && x >= X_W'(2) && y >= Y_W'(2);
  always_comb begin
    win_d[canny_pkg::WIN_TL] = win_q[canny_pkg::WIN_TC];
    win_d[canny_pkg::WIN_TC] = win_q[canny_pkg::WIN_TR];
    win_d[canny_pkg::WIN_TR] = tap_top;
    win_d[canny_pkg::WIN_ML] = win_q[canny_pkg::WIN_MC];
    win_d[canny_pkg::WIN_MC] = win_q[canny_pkg::WIN_MR];
    win_d[canny_pkg::WIN_MR] = tap_mid;
    win_d[canny_pkg::WIN_BL] = win_q[canny_pkg::WIN_BC];
    win_d[canny_pkg::WIN_BC] = win_q[canny_pkg::WIN_BR];
    win_d[canny_pkg::WIN_BR] = tap_bot;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q      <= 1'b0;
      sof_q     <= 1'b0;
      cap_q     <= 1'b0;
      win_q     <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      eof       <= 1'b0;
    end else begin
      ld_q      <= ld;
      sof_q     <= sof;
      cap_q     <= ld_q;
      win_valid <= in_img;
      eof       <= pos_eof;
      if (ld_q) win_q <= win_d;
      if (cap_q) win <= win_q;
      if (in_img) begin
        cx <= x - 1'b1;
        cy <= y - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_window_3x3_assembler.sv
// tb_window_3x3_assembler: random and ramp frames through a modelled line buffer, checked against a frame-level model
module tb_window_3x3_assembler;
  localparam int W = 8, H = 4, DW = 8;
  logic clk = 1'b0, rst = 1'b0, ld = 1'b0, sof = 1'b0;
  logic [DW-1:0] tap_top = '0, tap_mid = '0, tap_bot = '0;
  logic [9*DW-1:0] win;
  logic win_valid, eof;
  logic [2:0] cx;
  logic [1:0] cy;
  always #5 clk = ~clk;
  window_3x3_assembler #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ld(ld), .sof(sof), .tap_top(tap_top), .tap_mid(tap_mid), .tap_bot(tap_bot),
    .win(win), .win_valid(win_valid), .cx(cx), .cy(cy), .eof(eof)
  );
  typedef struct {bit l; bit v; bit e; logic [71:0] w; logic [2:0] cx; logic [1:0] cy;} rec_t;
  rec_t p1 = '{default: 0}, p2 = '{default: 0}, nr;
  logic [7:0] hist[$];
  logic [7:0] fm[H][W];
  bit ldh[$];
  int k = 0;
  bit started = 0, tv = 0;
  logic [7:0] nt_top, nt_mid, nt_bot;
  logic e_v = 0, e_eof = 0;
  logic [71:0] e_win = '0;
  logic [2:0] e_cx = '0;
  logic [1:0] e_cy = '0;
  logic [71:0] ref_wins[$], got[$];
  logic [9:0] sched[$];
  int vecs = 0, errs = 0;

  function automatic logic [7:0] ramp(int i);
    return 8'(i % W + 16 * (i / W));
  endfunction
  function automatic string obs();
    return $sformatf("v=%b eof=%b cx=%0d cy=%0d win=%h", win_valid, eof, cx, cy, win);
  endfunction
  function automatic string want();
    return $sformatf("v=%b eof=%b cx=%0d cy=%0d win=%h", e_v, e_eof, e_cx, e_cy, e_win);
  endfunction

  // One clock: drive inputs, feed the line-buffer model, and advance the frame-level expectation.
  task automatic tick(input bit r, input bit l, input bit s, input logic [7:0] px);
    int n, fx, fy;
    rst = r; ld = l; sof = s;
    tap_top = tv ? nt_top : 8'($urandom);
    tap_mid = tv ? nt_mid : 8'($urandom);
    tap_bot = tv ? nt_bot : 8'($urandom);
    tv = 0;
    if (l) begin
      hist.push_back(px);
      n = hist.size() - 1;
      nt_bot = px;
      nt_mid = n >= W ? hist[n-W] : 8'h0;
      nt_top = n >= 2*W ? hist[n-2*W] : 8'h0;
      tv = !r;
    end
    nr = '{default: 0};
    if (r) begin
      started = 0; k = 0;
    end else if (l) begin
      k = (s || !started) ? 0 : (k + 1) % (W * H);
      started = 1;
      fx = k % W; fy = k / W;
      fm[fy][fx] = px;
      nr.l = 1; nr.e = (k == W*H - 1); nr.v = (fx >= 2 && fy >= 2);
      nr.cx = 3'(fx - 1); nr.cy = 2'(fy - 1);
      if (nr.v)
        for (int rr = 0; rr < 3; rr++)
          for (int c = 0; c < 3; c++) nr.w[(3*rr+c)*8 +: 8] = fm[fy-2+rr][fx-2+c];
    end
    if (r) begin
      e_v = 0; e_eof = 0; e_win = '0; e_cx = '0; e_cy = '0;
      p1 = '{default: 0}; p2 = '{default: 0};
    end else begin
      e_v = p2.l && p2.v;
      e_eof = p2.l && p2.e;
      if (e_v) begin e_win = p2.w; e_cx = p2.cx; e_cy = p2.cy; end
      p2 = p1; p1 = nr;
    end
    ldh.push_back(l && !r);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 8'h0);
    tick(1, 1, 1, 8'hff);
    if ({win_valid, eof, cx, cy, win} !== '0) begin errs++; $display("FAIL reset got %s want all zero", obs()); end
    vecs++;
  endtask

  task automatic test_ramp;
    int nv = 0;
    bit first = 1;
    got.delete();
    for (int i = 0; i < W*H + 2; i++) begin
      tick(0, i < W*H, i == 0, ramp(i));
      if (win_valid !== e_v || eof !== e_eof || cx !== e_cx || cy !== e_cy || (e_v && win !== e_win)) begin
        errs++; $display("FAIL ramp_out t=%0d got %s want %s", i, obs(), want());
      end
      vecs++;
      if (win_valid) begin
        nv++; got.push_back(win);
        if (first) begin
          if (cx !== 3'd1 || cy !== 2'd1 || win !== 72'h222120121110020100) begin
            errs++; $display("FAIL ramp_first got %s want cx=1 cy=1 win=222120121110020100", obs());
          end
          vecs++; first = 0;
        end
        if (cx == 3'd1 && cy == 2'd2) begin
          if (win[7:0] !== 8'h10) begin errs++; $display("FAIL wrap_c0 got %h want 10", win[7:0]); end
          vecs++;
        end
      end
    end
    if (nv !== 12) begin errs++; $display("FAIL ramp_count got %0d want 12", nv); end
    vecs++;
    ref_wins = got;
  endtask

  task automatic test_gapped;
    bit seen = 0;
    got.delete(); sched.delete();
    for (int i = 0; i < W*H; i++) begin
      repeat ($urandom_range(0, 3)) sched.push_back({2'b00, 8'($urandom)});
      sched.push_back({1'b1, i == 0, ramp(i)});
    end
    repeat (2) sched.push_back(10'h0);
    foreach (sched[i]) begin
      tick(0, sched[i][9], sched[i][8], sched[i][7:0]);
      if (win_valid !== e_v || eof !== e_eof || cx !== e_cx || cy !== e_cy || (e_v && win !== e_win)) begin
        errs++; $display("FAIL gap_out t=%0d got %s want %s", i, obs(), want());
      end
      vecs++;
      if (win_valid) begin
        got.push_back(win);
        if (ldh[ldh.size()-3] !== 1'b1) begin errs++; $display("FAIL gap_latency t=%0d got no ld 2 cycles before, want ld", i); end
        vecs++;
      end
      seen |= !sched[i][9];
    end
    if (got.size() !== ref_wins.size()) begin errs++; $display("FAIL gap_count got %0d want %0d", got.size(), ref_wins.size()); end
    vecs++;
    foreach (got[i])
      if (i < ref_wins.size()) begin
        if (got[i] !== ref_wins[i]) begin errs++; $display("FAIL gap_win[%0d] got %h want %h", i, got[i], ref_wins[i]); end
        vecs++;
      end
    if (!seen) $display("note: gapped run drew no idle cycles");
  endtask

  task automatic test_eof_sof;
    int nv = 0, ne = 0;
    int len[3] = '{W*H, 2*W + 3, W*H};
    sched.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < len[f]; i++) begin
        if ($urandom_range(0, 3) == 0) sched.push_back({2'b00, 8'($urandom)});
        sched.push_back({1'b1, i == 0, 8'($urandom)});
      end
    repeat (2) sched.push_back(10'h0);
    foreach (sched[i]) begin
      tick(0, sched[i][9], sched[i][8], sched[i][7:0]);
      if (win_valid !== e_v || eof !== e_eof || cx !== e_cx || cy !== e_cy || (e_v && win !== e_win)) begin
        errs++; $display("FAIL eofsof_out t=%0d got %s want %s", i, obs(), want());
      end
      vecs++;
      nv += win_valid; ne += eof;
    end
    if (ne !== 2) begin errs++; $display("FAIL eof_count got %0d want 2", ne); end
    if (nv !== 25) begin errs++; $display("FAIL abort_valid_count got %0d want 25", nv); end
    vecs += 2;
  endtask

  task automatic test_rst_mid;
    for (int i = 0; i < 2*W + 5; i++) tick(0, 1, i == 0, ramp(i));
    tick(1, 0, 0, 8'h0);
    if ({win_valid, eof, cx, cy, win} !== '0) begin errs++; $display("FAIL rst_mid got %s want all zero", obs()); end
    vecs++;
    got.delete();
    for (int i = 0; i < W*H + 2; i++) begin
      tick(0, i < W*H, i == 0, ramp(i));
      if (win_valid !== e_v || eof !== e_eof || cx !== e_cx || cy !== e_cy || (e_v && win !== e_win)) begin
        errs++; $display("FAIL rst_mid_out t=%0d got %s want %s", i, obs(), want());
      end
      vecs++;
      if (win_valid) got.push_back(win);
    end
    if (got.size() !== 12) begin errs++; $display("FAIL rst_mid_count got %0d want 12", got.size()); end
    vecs++;
    foreach (got[i])
      if (i < ref_wins.size()) begin
        if (got[i] !== ref_wins[i]) begin errs++; $display("FAIL rst_mid_win[%0d] got %h want %h", i, got[i], ref_wins[i]); end
        vecs++;
      end
  endtask

  task automatic test_rst_ld;
    int nv = 0;
    logic [2:0] fcx = '1;
    logic [1:0] fcy = '1;
    tick(1, 1, 0, 8'h55);
    if ({win_valid, eof, cx, cy, win} !== '0) begin errs++; $display("FAIL rst_ld got %s want all zero", obs()); end
    vecs++;
    for (int i = 0; i < 2*W + 5; i++) begin
      tick(0, i < 2*W + 3, 0, ramp(i));
      if (win_valid !== e_v || eof !== e_eof || cx !== e_cx || cy !== e_cy || (e_v && win !== e_win)) begin
        errs++; $display("FAIL rst_ld_out t=%0d got %s want %s", i, obs(), want());
      end
      vecs++;
      if (win_valid) begin nv++; fcx = cx; fcy = cy; end
    end
    if (nv !== 1 || fcx !== 3'd1 || fcy !== 2'd1) begin
      errs++; $display("FAIL rst_ld_pos got count=%0d cx=%0d cy=%0d want count=1 cx=1 cy=1", nv, fcx, fcy);
    end
    vecs++;
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_gapped;
    test_eof_sof;
    test_rst_mid;
    test_rst_ld;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
